// File: rtl/bus_err_inject_bare.sv
// bus_err_inject_bare: rewrites the error code of bus responses whose
// originating request matched an armed address window.
// Accepted requests push an in-order tag FIFO that is popped on each
// response's last beat.
// Define BUS_ERR_INJECT_LOG_EN to store each request address in its tag and
// report the address of the most recent injected response on inj_last_addr_o.
// When it is undefined, inj_last_addr_o is tied to zero.
module bus_err_inject_bare #(
    parameter int AddrWidth      = 48,
    parameter int ErrBits        = 3,
    parameter int NumOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_hs_valid_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 rsp_hs_valid_i,
    input  logic                 rsp_burst_last_i,
    input  logic [ErrBits-1:0]   rsp_err_i,
    output logic [ErrBits-1:0]   rsp_err_o,
    input  logic                 inj_arm_i,
    input  logic                 inj_disarm_i,
    input  logic [AddrWidth-1:0] inj_base_i,
    input  logic [AddrWidth-1:0] inj_mask_i,
    input  logic [ErrBits-1:0]   inj_code_i,
    input  logic [7:0]           inj_count_i,
    output logic [1:0]           inj_state_o,
    output logic                 inj_done_o,
    output logic [15:0]          inj_total_o,
    output logic                 overflow_o,
    output logic [AddrWidth-1:0] inj_last_addr_o
);

    localparam int PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int CntW = $clog2(NumOutstanding + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NumOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [NumOutstanding-1:0] tag_flag;
    logic [PtrW-1:0]       wr_ptr, rd_ptr;
    logic [CntW-1:0]       fill, tag_cnt, tag_cnt_next;
    logic [7:0]            budget;
    logic                  unlimited;
    logic                  dead;
    logic                  overflow;
    logic [15:0]           total;
    logic                  load_budget;

    logic match, empty, full, push_req, pop_req, push, pop, overflow_evt;
    logic head_flag, inject_flag, tag_push, tag_pop;

    // Handshake qualification: dead mode blocks all FIFO traffic and injection.
    always_comb begin
        match        = ((req_addr_i ^ inj_base_i) & inj_mask_i) == '0;
        empty        = (fill == '0);
        full         = (fill == FullCnt);
        push_req     = req_hs_valid_i & ~dead;
        pop_req      = rsp_hs_valid_i & rsp_burst_last_i & ~dead;
        pop          = pop_req & ~empty;
        push         = push_req & (~full | pop);
        overflow_evt = push_req & full & ~pop;
        head_flag    = ~dead & ~empty & tag_flag[rd_ptr];
        inject_flag  = match & (state == ARMED) & (unlimited | (budget != 8'd0));
        tag_push     = push & inject_flag;
        tag_pop      = pop & head_flag;
    end

    // Tagged-outstanding count as it will be after this cycle's push/pop.
    always_comb begin
        tag_cnt_next = tag_cnt;
        if (tag_push && !tag_pop) begin
            tag_cnt_next = tag_cnt + CntW'(1);
        end else if (!tag_push && tag_pop) begin
            tag_cnt_next = tag_cnt - CntW'(1);
        end
    end

    // Next state; disarm beats everything, tracking loss drops back to IDLE.
    always_comb begin
        state_next  = state;
        load_budget = 1'b0;
        if (inj_disarm_i) begin
            state_next = IDLE;
        end else if (overflow_evt) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (inj_arm_i && empty && !dead) begin
                        state_next  = ARMED;
                        load_budget = 1'b1;
                    end
                end
                ARMED: begin
                    if (tag_push && !unlimited && budget == 8'd1) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (tag_cnt_next == '0) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO pointers, occupancy and tagged-outstanding counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
            end
            if (push && !pop) begin
                fill <= fill + CntW'(1);
            end else if (!push && pop) begin
                fill <= fill - CntW'(1);
            end
            tag_cnt <= tag_cnt_next;
        end
    end

    // Tag storage; entries are only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_flag[wr_ptr] <= inject_flag;
        end
    end

    // Injection budget: loaded on arm, zero means unlimited.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            budget    <= 8'd0;
            unlimited <= 1'b0;
        end else if (load_budget) begin
            budget    <= inj_count_i;
            unlimited <= (inj_count_i == 8'd0);
        end else if (tag_push && !unlimited && budget != 8'd0) begin
            budget <= budget - 8'd1;
        end
    end

    // Sticky tracking-loss flag, saturating injected-response counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dead     <= 1'b0;
            overflow <= 1'b0;
            total    <= 16'd0;
        end else begin
            if (overflow_evt) begin
                dead     <= 1'b1;
                overflow <= 1'b1;
            end
            if (tag_pop && total != 16'hFFFF) begin
                total <= total + 16'd1;
            end
        end
    end

`ifdef BUS_ERR_INJECT_LOG_EN
    logic [AddrWidth-1:0] tag_addr [NumOutstanding];
    logic [AddrWidth-1:0] last_addr;

    // Address half of each tag.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_addr[wr_ptr] <= req_addr_i;
        end
    end

    // Remember the address of the latest injected response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_addr <= '0;
        end else if (tag_pop) begin
            last_addr <= tag_addr[rd_ptr];
        end
    end

    assign inj_last_addr_o = last_addr;
`else
    assign inj_last_addr_o = '0;
`endif

    assign rsp_err_o   = (rsp_hs_valid_i && head_flag) ? inj_code_i : rsp_err_i;
    assign inj_state_o = state;
    assign inj_done_o  = (state == DONE);
    assign inj_total_o = total;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_bus_err_inject_bare.sv
// Directed testbench for bus_err_inject_bare (default parameters).
module tb_bus_err_inject_bare;

    localparam int AddrWidth = 48;
    localparam int ErrBits   = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_hs_valid_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 rsp_hs_valid_i;
    logic                 rsp_burst_last_i;
    logic [ErrBits-1:0]   rsp_err_i;
    logic [ErrBits-1:0]   rsp_err_o;
    logic                 inj_arm_i;
    logic                 inj_disarm_i;
    logic [AddrWidth-1:0] inj_base_i;
    logic [AddrWidth-1:0] inj_mask_i;
    logic [ErrBits-1:0]   inj_code_i;
    logic [7:0]           inj_count_i;
    logic [1:0]           inj_state_o;
    logic                 inj_done_o;
    logic [15:0]          inj_total_o;
    logic                 overflow_o;
    logic [AddrWidth-1:0] inj_last_addr_o;

    int checks = 0;
    int fails  = 0;

    bus_err_inject_bare #(
        .AddrWidth(AddrWidth),
        .ErrBits(ErrBits),
        .NumOutstanding(4)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_hs_valid_i(req_hs_valid_i),
        .req_addr_i(req_addr_i),
        .rsp_hs_valid_i(rsp_hs_valid_i),
        .rsp_burst_last_i(rsp_burst_last_i),
        .rsp_err_i(rsp_err_i),
        .rsp_err_o(rsp_err_o),
        .inj_arm_i(inj_arm_i),
        .inj_disarm_i(inj_disarm_i),
        .inj_base_i(inj_base_i),
        .inj_mask_i(inj_mask_i),
        .inj_code_i(inj_code_i),
        .inj_count_i(inj_count_i),
        .inj_state_o(inj_state_o),
        .inj_done_o(inj_done_o),
        .inj_total_o(inj_total_o),
        .overflow_o(overflow_o),
        .inj_last_addr_o(inj_last_addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_arm(input logic [7:0] count);
        inj_count_i = count;
        inj_arm_i   = 1'b1;
        tick();
        inj_arm_i   = 1'b0;
    endtask

    task automatic pulse_disarm();
        inj_disarm_i = 1'b1;
        tick();
        inj_disarm_i = 1'b0;
    endtask

    task automatic push_req(input logic [AddrWidth-1:0] addr);
        req_hs_valid_i = 1'b1;
        req_addr_i     = addr;
        tick();
        req_hs_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni           = 1'b0;
        req_hs_valid_i   = 1'b0;
        req_addr_i       = '0;
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        rsp_err_i        = '0;
        inj_arm_i        = 1'b0;
        inj_disarm_i     = 1'b0;
        inj_base_i       = 48'h1000;
        inj_mask_i       = 48'hFFFF_FFFF_F000;
        inj_code_i       = 3'd5;
        inj_count_i      = 8'd0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %0d expected 0", inj_state_o);
        end
        checks++;
        if ({inj_done_o, overflow_o} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_flags: got done=%0b ovf=%0b expected 0 0", inj_done_o, overflow_o);
        end
        checks++;
        if (inj_total_o !== 16'd0 || inj_last_addr_o !== 48'd0) begin
            fails++;
            $display("[TB] FAIL reset_counters: got total=%0h last=%0h expected 0 0", inj_total_o, inj_last_addr_o);
        end
        rsp_hs_valid_i   = 1'b1;
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd6;
        #1;
        checks++;
        if (rsp_err_o !== 3'd6) begin
            fails++;
            $display("[TB] FAIL reset_passthru: got %0d expected 6", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        rsp_err_i        = 3'd0;
    endtask

    task automatic test_budget();
        logic [AddrWidth-1:0] addrs [4];
        logic [ErrBits-1:0]   exp_err [4];
        logic [1:0]           exp_state [4];
        addrs     = '{48'h1004, 48'h2000, 48'h1FF0, 48'h1008};
        exp_err   = '{3'd5, 3'd0, 3'd5, 3'd0};
        exp_state = '{2'd2, 2'd2, 2'd3, 2'd3};
        pulse_arm(8'd2);
        checks++;
        if (inj_state_o !== 2'd1) begin
            fails++;
            $display("[TB] FAIL budget_armed: got %0d expected 1", inj_state_o);
        end
        for (int i = 0; i < 4; i++) begin
            push_req(addrs[i]);
            if (i == 2) begin
                checks++;
                if (inj_state_o !== 2'd2) begin
                    fails++;
                    $display("[TB] FAIL budget_drain: got %0d expected 2", inj_state_o);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            rsp_hs_valid_i   = 1'b1;
            rsp_burst_last_i = 1'b1;
            rsp_err_i        = 3'd0;
            #1;
            checks++;
            if (rsp_err_o !== exp_err[i]) begin
                fails++;
                $display("[TB] FAIL budget_rsp%0d: got %0d expected %0d", i, rsp_err_o, exp_err[i]);
            end
            tick();
            rsp_hs_valid_i   = 1'b0;
            rsp_burst_last_i = 1'b0;
            checks++;
            if (inj_state_o !== exp_state[i]) begin
                fails++;
                $display("[TB] FAIL budget_state%0d: got %0d expected %0d", i, inj_state_o, exp_state[i]);
            end
        end
        checks++;
        if (inj_done_o !== 1'b1 || inj_total_o !== 16'd2) begin
            fails++;
            $display("[TB] FAIL budget_done_total: got done=%0b total=%0d expected 1 2", inj_done_o, inj_total_o);
        end
    endtask

    task automatic test_unlimited();
        pulse_arm(8'd0);
        for (int i = 0; i < 5; i++) begin
            push_req(48'h1000 + 48'(i * 4));
            rsp_hs_valid_i   = 1'b1;
            rsp_burst_last_i = 1'b1;
            rsp_err_i        = 3'd1;
            #1;
            checks++;
            if (rsp_err_o !== 3'd5) begin
                fails++;
                $display("[TB] FAIL unlimited_rsp%0d: got %0d expected 5", i, rsp_err_o);
            end
            tick();
            rsp_hs_valid_i   = 1'b0;
            rsp_burst_last_i = 1'b0;
        end
        checks++;
        if (inj_state_o !== 2'd1 || inj_total_o !== 16'd7) begin
            fails++;
            $display("[TB] FAIL unlimited_end: got state=%0d total=%0d expected 1 7", inj_state_o, inj_total_o);
        end
        pulse_disarm();
        checks++;
        if (inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL unlimited_disarm: got %0d expected 0", inj_state_o);
        end
    endtask

    task automatic test_burst();
        inj_code_i = 3'd3;
        pulse_arm(8'd0);
        push_req(48'h1010);
        push_req(48'h3000);
        for (int b = 0; b < 4; b++) begin
            rsp_hs_valid_i   = 1'b1;
            rsp_burst_last_i = (b == 3);
            rsp_err_i        = 3'd1;
            #1;
            checks++;
            if (rsp_err_o !== 3'd3) begin
                fails++;
                $display("[TB] FAIL burst_beat%0d: got %0d expected 3", b, rsp_err_o);
            end
            tick();
        end
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd2;
        #1;
        checks++;
        if (rsp_err_o !== 3'd2) begin
            fails++;
            $display("[TB] FAIL burst_next_passthru: got %0d expected 2", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        checks++;
        if (inj_total_o !== 16'd8) begin
            fails++;
            $display("[TB] FAIL burst_total: got %0d expected 8", inj_total_o);
        end
        pulse_disarm();
        inj_code_i = 3'd5;
    endtask

    task automatic test_arm_blocked();
        push_req(48'h1000);
        pulse_arm(8'd0);
        checks++;
        if (inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL arm_blocked_state: got %0d expected 0", inj_state_o);
        end
        rsp_hs_valid_i   = 1'b1;
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd4;
        #1;
        checks++;
        if (rsp_err_o !== 3'd4) begin
            fails++;
            $display("[TB] FAIL arm_blocked_rsp: got %0d expected 4", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        pulse_arm(8'd0);
        checks++;
        if (inj_state_o !== 2'd1) begin
            fails++;
            $display("[TB] FAIL arm_after_rsp: got %0d expected 1", inj_state_o);
        end
        pulse_disarm();
        inj_arm_i    = 1'b1;
        inj_disarm_i = 1'b1;
        tick();
        inj_arm_i    = 1'b0;
        inj_disarm_i = 1'b0;
        checks++;
        if (inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL disarm_wins: got %0d expected 0", inj_state_o);
        end
    endtask

    task automatic test_log();
        logic [AddrWidth-1:0] exp_addr;
`ifdef BUS_ERR_INJECT_LOG_EN
        exp_addr = 48'h1ABC;
`else
        exp_addr = 48'h0;
`endif
        pulse_arm(8'd0);
        push_req(48'h1ABC);
        rsp_hs_valid_i   = 1'b1;
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd0;
        #1;
        checks++;
        if (rsp_err_o !== 3'd5) begin
            fails++;
            $display("[TB] FAIL log_rsp: got %0d expected 5", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        checks++;
        if (inj_last_addr_o !== exp_addr) begin
            fails++;
            $display("[TB] FAIL log_addr: got %0h expected %0h", inj_last_addr_o, exp_addr);
        end
        checks++;
        if (inj_total_o !== 16'd9) begin
            fails++;
            $display("[TB] FAIL log_total: got %0d expected 9", inj_total_o);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            push_req(48'h1000 + 48'(i * 16));
        end
        checks++;
        if (overflow_o !== 1'b0 || inj_state_o !== 2'd1) begin
            fails++;
            $display("[TB] FAIL ovf_full_ok: got ovf=%0b state=%0d expected 0 1", overflow_o, inj_state_o);
        end
        push_req(48'h1040);
        checks++;
        if (overflow_o !== 1'b1 || inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL ovf_set: got ovf=%0b state=%0d expected 1 0", overflow_o, inj_state_o);
        end
        rsp_hs_valid_i   = 1'b1;
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd2;
        #1;
        checks++;
        if (rsp_err_o !== 3'd2) begin
            fails++;
            $display("[TB] FAIL ovf_passthru: got %0d expected 2", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        pulse_arm(8'd0);
        checks++;
        if (inj_state_o !== 2'd0 || overflow_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_arm_ignored: got state=%0d ovf=%0b expected 0 1", inj_state_o, overflow_o);
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        checks++;
        if (overflow_o !== 1'b0 || inj_total_o !== 16'd0 || inj_state_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL ovf_reset: got ovf=%0b total=%0d state=%0d expected 0 0 0", overflow_o, inj_total_o, inj_state_o);
        end
        rsp_hs_valid_i   = 1'b1;
        rsp_burst_last_i = 1'b1;
        rsp_err_i        = 3'd1;
        #1;
        checks++;
        if (rsp_err_o !== 3'd1) begin
            fails++;
            $display("[TB] FAIL reset_discard_tags: got %0d expected 1", rsp_err_o);
        end
        tick();
        rsp_hs_valid_i   = 1'b0;
        rsp_burst_last_i = 1'b0;
        pulse_arm(8'd0);
        checks++;
        if (inj_state_o !== 2'd1) begin
            fails++;
            $display("[TB] FAIL rearm_after_reset: got %0d expected 1", inj_state_o);
        end
    endtask

    // Scenario sequence; each task leaves the FIFO empty for the next one.
    initial begin
        test_reset();
        test_budget();
        test_unlimited();
        test_burst();
        test_arm_blocked();
        test_log();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
